// File: rtl/alu_share_arbiter_if.sv
// Bus bundle between the two requesters, the shared ALU and the response consumer.
// The arbiter uses modport slave; the surrounding environment uses modport master.
interface alu_share_arbiter_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned OPW   = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_op;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_r;
    logic             alu_z;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_result;
    logic             resp_zero;
    logic             resp_err;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_r, alu_z,
        output resp_valid, resp_id, resp_result, resp_zero, resp_err,
        input  resp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_r, alu_z,
        input  resp_valid, resp_id, resp_result, resp_zero, resp_err,
        output resp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, with a
// single registered response slot tagged by requester id.
// Optional macro ALU_ARB_OPCHECK_EN: illegal opcodes are accepted but the ALU
// sees opcode 0 and the slot stores result 0, zero 1, err 1.
module alu_share_arbiter #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned OPW   = 4
) (
    input logic            clk,
    input logic            reset,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             resp_id_q, resp_id_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic             grant_vld;
    logic             grant_id;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [OPW-1:0]   sel_op;
    logic             op_bad;

`ifdef ALU_ARB_OPCHECK_EN
    localparam logic [OPW-1:0] OP_AND = OPW'(4'b0000);
    localparam logic [OPW-1:0] OP_OR  = OPW'(4'b0001);
    localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0010);
    localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0110);
    localparam logic [OPW-1:0] OP_NOR = OPW'(4'b1100);
    logic err_q, err_d;
`endif

    // Round-robin grant: a lone requester wins, contention goes to the one not served last.
    always_comb begin
        grant_vld = bus.req0_valid || bus.req1_valid;
        grant_id  = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant_q;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
        sel_a  = grant_id ? bus.req1_a  : bus.req0_a;
        sel_b  = grant_id ? bus.req1_b  : bus.req0_b;
        sel_op = grant_id ? bus.req1_op : bus.req0_op;
`ifdef ALU_ARB_OPCHECK_EN
        op_bad = grant_vld && !(sel_op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR});
`else
        op_bad = 1'b0;
`endif
    end

    // Slot FSM next state and capture of the ALU result on an accept.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        resp_id_d    = resp_id_q;
        result_d     = result_q;
        zero_d       = zero_q;
`ifdef ALU_ARB_OPCHECK_EN
        err_d        = err_q;
`endif
        accept = grant_vld && !reset && ((state_q == EMPTY) || bus.resp_ready);

        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (!accept && bus.resp_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase

        if (accept) begin
            last_grant_d = grant_id;
            resp_id_d    = grant_id;
            result_d     = op_bad ? '0 : bus.alu_r;
            zero_d       = op_bad ? 1'b1 : bus.alu_z;
`ifdef ALU_ARB_OPCHECK_EN
            err_d        = op_bad;
`endif
        end
    end

    // State and response registers; reset discards any held response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            last_grant_q <= 1'b1;
            resp_id_q    <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            resp_id_q    <= resp_id_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
`ifdef ALU_ARB_OPCHECK_EN
            err_q        <= err_d;
`endif
        end
    end

    assign bus.req0_ready  = accept && !grant_id;
    assign bus.req1_ready  = accept && grant_id;
    assign bus.alu_a       = grant_vld ? sel_a : '0;
    assign bus.alu_b       = grant_vld ? sel_b : '0;
    assign bus.alu_op      = (grant_vld && !op_bad) ? sel_op : '0;
    assign bus.resp_valid  = (state_q == FULL);
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_result = result_q;
    assign bus.resp_zero   = zero_q;
`ifdef ALU_ARB_OPCHECK_EN
    assign bus.resp_err    = err_q;
`else
    assign bus.resp_err    = 1'b0;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: a reference ALU, a transaction-level
// model of the arbiter checked every cycle, and directed scenarios with literal values.
module tb_alu_share_arbiter;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned OPW   = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   started = 1'b0;

    alu_share_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();
    alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Reference ALU attached to the DUT's ALU ports.
    function automatic logic [63:0] alu_fn(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b1100: return ~(a | b);
            default: return a ^ b ^ 64'h5A5A_5A5A_5A5A_5A5A;
        endcase
    endfunction

    function automatic bit op_legal(input logic [3:0] op);
        return op == 4'b0000 || op == 4'b0001 || op == 4'b0010 || op == 4'b0110 || op == 4'b1100;
    endfunction

    assign bus.alu_r = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
    assign bus.alu_z = (bus.alu_r == 64'd0);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the response slot: what the consumer must see, and who was served last.
    bit          m_full, m_id, m_zero, m_err, m_last;
    logic [63:0] m_res;

    // Which requester the rules say is served this cycle, if any ({valid, id}).
    function automatic logic [1:0] who_wins();
        if (bus.req0_valid && bus.req1_valid) return {1'b1, ~m_last};
        if (bus.req0_valid) return 2'b10;
        if (bus.req1_valid) return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit op_forced_zero(input logic [3:0] op);
`ifdef ALU_ARB_OPCHECK_EN
        return !op_legal(op);
`else
        return 1'b0;
`endif
    endfunction

    // Advance the model at each edge from the inputs presented in that cycle.
    always @(posedge clk) begin
        logic [1:0]  g;
        bit          taken;
        logic [63:0] a, b;
        logic [3:0]  op;
        g     = who_wins();
        taken = g[1] && !reset && (!m_full || bus.resp_ready);
        a  = g[0] ? bus.req1_a  : bus.req0_a;
        b  = g[0] ? bus.req1_b  : bus.req0_b;
        op = g[0] ? bus.req1_op : bus.req0_op;
        if (reset) begin
            m_full = 0; m_id = 0; m_res = '0; m_zero = 0; m_err = 0; m_last = 1;
        end else if (taken) begin
            m_full = 1; m_id = g[0]; m_last = g[0];
            if (op_forced_zero(op)) begin
                m_res = '0; m_zero = 1; m_err = 1;
            end else begin
                m_res = alu_fn(a, b, op); m_zero = (m_res == 0); m_err = 0;
            end
        end else if (m_full && bus.resp_ready) begin
            m_full = 0;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            logic [1:0] g;
            bit         taken;
            logic [3:0] op;
            g     = who_wins();
            taken = g[1] && !reset && (!m_full || bus.resp_ready);
            op    = g[0] ? bus.req1_op : bus.req0_op;
            check("req0_ready", 64'(bus.req0_ready), 64'(taken && !g[0]));
            check("req1_ready", 64'(bus.req1_ready), 64'(taken && g[0]));
            check("alu_a", bus.alu_a, !g[1] ? 64'd0 : (g[0] ? bus.req1_a : bus.req0_a));
            check("alu_b", bus.alu_b, !g[1] ? 64'd0 : (g[0] ? bus.req1_b : bus.req0_b));
            check("alu_op", 64'(bus.alu_op), (!g[1] || op_forced_zero(op)) ? 64'd0 : 64'(op));
            check("resp_valid", 64'(bus.resp_valid), 64'(m_full));
            check("resp_id", 64'(bus.resp_id), 64'(m_id));
            check("resp_result", bus.resp_result, m_res);
            check("resp_zero", 64'(bus.resp_zero), 64'(m_zero));
            check("resp_err", 64'(bus.resp_err), 64'(m_err));
        end
    end

    task automatic set0(input bit v, input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
        bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    endtask

    task automatic set1(input bit v, input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
        bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_id;
        reset = 1'b1;
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        bus.resp_ready = 1'b0;
        next_cycle();
        started = 1'b1;
        @(negedge clk);
        check("lit_rst_valid", 64'(bus.resp_valid), 64'd0);
        check("lit_rst_result", bus.resp_result, 64'd0);

        // Single op: ADD 5+7 accepted immediately, response one cycle later.
        next_cycle();
        reset = 1'b0;
        set0(1, 64'd5, 64'd7, 4'b0010);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("lit_single_ready0", 64'(bus.req0_ready), 64'd1);
        next_cycle();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("lit_single_valid", 64'(bus.resp_valid), 64'd1);
        check("lit_single_id", 64'(bus.resp_id), 64'd0);
        check("lit_single_result", bus.resp_result, 64'd12);
        check("lit_single_zero", 64'(bus.resp_zero), 64'd0);

        // Contention: req0 was served last, so req1 leads, then strict alternation.
        next_cycle();
        set0(1, 64'd9, 64'd9, 4'b0110);
        set1(1, 64'hF0, 64'h0F, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            @(negedge clk);
            exp_id = (i % 2 == 0);
            check("lit_cont_valid", 64'(bus.resp_valid), 64'd1);
            check("lit_cont_id", 64'(bus.resp_id), 64'(exp_id));
            check("lit_cont_result", bus.resp_result, exp_id ? 64'hFF : 64'd0);
            check("lit_cont_zero", 64'(bus.resp_zero), exp_id ? 64'd0 : 64'd1);
        end

        // Backpressure: slot holds req1 AND result while req0 waits.
        next_cycle();
        set0(0, 0, 0, 0);
        set1(1, 64'hFF, 64'h0F, 4'b0000);
        next_cycle();
        set1(0, 0, 0, 0);
        set0(1, 64'd1, 64'd2, 4'b0010);
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lit_bp_ready0", 64'(bus.req0_ready), 64'd0);
            check("lit_bp_result", bus.resp_result, 64'h0F);
            next_cycle();
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("lit_bp_release_ready0", 64'(bus.req0_ready), 64'd1);
        next_cycle();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("lit_bp_full", 64'(bus.resp_valid), 64'd1);
        check("lit_bp_result2", bus.resp_result, 64'd3);

        // Priority hold: req0 served last; a stall must not rotate priority.
        set0(1, 64'd10, 64'd20, 4'b0010);
        set1(1, 64'd50, 64'd8, 4'b0110);
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            @(negedge clk);
            check("lit_hold_ready1", 64'(bus.req1_ready), 64'd0);
        end
        next_cycle();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("lit_hold_first_ready1", 64'(bus.req1_ready), 64'd1);
        check("lit_hold_first_ready0", 64'(bus.req0_ready), 64'd0);
        next_cycle();
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check("lit_hold_result1", bus.resp_result, 64'd42);
        next_cycle();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("lit_hold_result0", bus.resp_result, 64'd30);

        // Reset while FULL discards the slot; first contention afterwards goes to req0.
        set0(1, 64'd1, 64'd1, 4'b0010);
        set1(1, 64'd2, 64'd2, 4'b0010);
        bus.resp_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("lit_rst_mid_ready0", 64'(bus.req0_ready), 64'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("lit_rst_mid_valid", 64'(bus.resp_valid), 64'd0);
        check("lit_rst_mid_result", bus.resp_result, 64'd0);
        check("lit_rst_mid_ready0b", 64'(bus.req0_ready), 64'd1);
        next_cycle();
        bus.req0_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("lit_rst_mid_id", 64'(bus.resp_id), 64'd0);
        check("lit_rst_mid_res", bus.resp_result, 64'd2);
        next_cycle();
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check("lit_rst_mid_res1", bus.resp_result, 64'd4);

`ifdef ALU_ARB_OPCHECK_EN
        // Illegal opcode consumes a slot with a flagged zero result; a legal NOR follows.
        set0(1, 64'd3, 64'd4, 4'b0111);
        @(negedge clk);
        check("lit_chk_alu_op", 64'(bus.alu_op), 64'd0);
        next_cycle();
        set0(1, 64'd0, 64'd0, 4'b1100);
        @(negedge clk);
        check("lit_chk_err", 64'(bus.resp_err), 64'd1);
        check("lit_chk_result", bus.resp_result, 64'd0);
        check("lit_chk_zero", 64'(bus.resp_zero), 64'd1);
        next_cycle();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("lit_nor_result", bus.resp_result, 64'hFFFF_FFFF_FFFF_FFFF);
        check("lit_nor_err", 64'(bus.resp_err), 64'd0);
`else
        check("lit_err_tied", 64'(bus.resp_err), 64'd0);
`endif

        // Drain without accept: slot empties, data holds.
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("lit_drain_valid", 64'(bus.resp_valid), 64'd0);
        check("lit_drain_alu_a", bus.alu_a, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
